// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: index -> tuning word (shift-add multiply), phase accumulation, ROM address.
// Optional macro DDS_PHASE_SYNC_EN: defer tuning-word load to the next accumulator wrap.
module dds_phase_accum #(
    parameter int ACC_W   = 32,
    parameter int ROM_AW  = 10,
    parameter int IDX_W   = 11,
    parameter int TW_STEP = 2386,
    parameter int MAX_IDX = 1799
) (
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic [IDX_W-1:0]  Address,
    input  logic              FreqChng,
    input  logic              Enable,
    output logic [ROM_AW-1:0] RomAddr,
    output logic              PhaseWrap,
    output logic [ACC_W-1:0]  TuneWord,
    output logic              Busy,
    output logic              UpdateDone
);

    localparam int MC_W  = IDX_W + 1;
    localparam int CNT_W = $clog2(MC_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MC_W - 1);
    localparam logic [ACC_W-1:0] TW_BASE  = ACC_W'(TW_STEP);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        APPLY,
        WAIT_WRAP
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  tune_q, tune_d;
    logic [ACC_W-1:0]  prod_q, prod_d;
    logic [MC_W-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              pend_q, pend_d;
    logic [IDX_W-1:0]  pidx_q, pidx_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
`ifdef DDS_PHASE_SYNC_EN
    logic              load_q, load_d;
`endif

    logic [ACC_W:0]    sum;
    logic              carry;
    logic [IDX_W-1:0]  req_idx;
    logic              start;
    logic [IDX_W-1:0]  start_idx;

    function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] a);
        return (a > IDX_W'(MAX_IDX)) ? IDX_W'(MAX_IDX) : a;
    endfunction

    // Phase accumulator: add the applied tuning word, expose the carry as the wrap strobe
    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, tune_q};
        carry  = Enable & sum[ACC_W];
        acc_d  = Enable ? sum[ACC_W-1:0] : '0;
        wrap_d = carry;
    end

    // Request sequencing: clamp/latch requests, multiply LSB-first, apply the result
    always_comb begin
        state_d   = state_q;
        tune_d    = tune_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        bitcnt_d  = bitcnt_q;
        pend_d    = pend_q;
        pidx_d    = pidx_q;
        done_d    = 1'b0;
        start     = 1'b0;
        start_idx = '0;
        req_idx   = clamp_idx(Address);
`ifdef DDS_PHASE_SYNC_EN
        load_d    = 1'b0;
        done_d    = load_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (FreqChng) begin
                    start     = 1'b1;
                    start_idx = req_idx;
                end
            end
            CALC: begin
                if (mcand_q[bitcnt_q]) begin
                    prod_d = prod_q + (TW_BASE << bitcnt_q);
                end
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == LAST_BIT) begin
`ifdef DDS_PHASE_SYNC_EN
                    state_d = WAIT_WRAP;
`else
                    state_d = APPLY;
`endif
                end
                if (FreqChng) begin
                    pend_d = 1'b1;
                    pidx_d = req_idx;
                end
            end
`ifdef DDS_PHASE_SYNC_EN
            WAIT_WRAP: begin
                if (carry || !Enable) begin
                    tune_d = prod_q;
                    load_d = 1'b1;
                    state_d = IDLE;
                    if (FreqChng) begin
                        start     = 1'b1;
                        start_idx = req_idx;
                    end else if (pend_q) begin
                        start     = 1'b1;
                        start_idx = pidx_q;
                    end
                    pend_d = 1'b0;
                end else if (FreqChng) begin
                    pend_d = 1'b1;
                    pidx_d = req_idx;
                end
            end
`else
            APPLY: begin
                tune_d  = prod_q;
                done_d  = 1'b1;
                state_d = IDLE;
                if (FreqChng) begin
                    start     = 1'b1;
                    start_idx = req_idx;
                end else if (pend_q) begin
                    start     = 1'b1;
                    start_idx = pidx_q;
                end
                pend_d = 1'b0;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start) begin
            mcand_d  = MC_W'(start_idx) + MC_W'(1);
            prod_d   = '0;
            bitcnt_d = '0;
            state_d  = CALC;
        end
    end

    // State and output registers; reset discards any in-flight product
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            tune_q   <= TW_BASE;
            prod_q   <= '0;
            mcand_q  <= '0;
            bitcnt_q <= '0;
            pend_q   <= 1'b0;
            pidx_q   <= '0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DDS_PHASE_SYNC_EN
            load_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            tune_q   <= tune_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            bitcnt_q <= bitcnt_d;
            pend_q   <= pend_d;
            pidx_q   <= pidx_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
`ifdef DDS_PHASE_SYNC_EN
            load_q   <= load_d;
`endif
        end
    end

    assign RomAddr    = acc_q[ACC_W-1 -: ROM_AW];
    assign PhaseWrap  = wrap_q;
    assign TuneWord   = tune_q;
    assign Busy       = (state_q != IDLE);
    assign UpdateDone = done_q;

endmodule
